comb_rr_sched: RTL and testbench

- Round-robin scheduler that shares one combinational activation unit (bias subtract + logistic) among NUM_REQ requesters.
- Accepts at most one (data, bias) operand pair per cycle from the granted requester and drives it into the shared unit.
- Registers the activated result with the originating requester ID into a single-entry output stage under valid/ready backpressure.
- Sits between the per-lane update engines and the shared activation datapath.

---
 rtl/comb_rr_sched.sv | 127 ++++++++++++
 tb/tb_comb_rr_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_rr_sched.sv
// Round-robin front end for one shared combinational activation unit.
// Optional statistics counters are enabled by defining COMB_RR_SCHED_STAT_EN.
module comb_rr_sched #(
  parameter int BITWIDTH = 8,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_data,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_bias,
  output logic [BITWIDTH-1:0]          comb_data_in,
  output logic [BITWIDTH-1:0]          comb_bias,
  output logic                         comb_valid,
  input  logic [BITWIDTH-1:0]          comb_data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITWIDTH-1:0]          out_data,
  output logic [ID_W-1:0]              out_id
`ifdef COMB_RR_SCHED_STAT_EN
  ,
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  xfer_cnt
`endif
);

  logic [ID_W-1:0]     last_gnt_r;
  logic                out_valid_r;
  logic [BITWIDTH-1:0] out_data_r;
  logic [ID_W-1:0]     out_id_r;
  logic [ID_W-1:0]     winner_s;
  logic                any_req_s;
  logic                can_accept_s;
  logic                xfer_s;

  // Rotating priority search; walking the offsets from farthest to nearest lets the nearest hit win.
  always_comb begin
    winner_s  = '0;
    any_req_s = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      winner_s  = req_valid[ID_W'((int'(last_gnt_r) + k) % NUM_REQ)]
                  ? ID_W'((int'(last_gnt_r) + k) % NUM_REQ) : winner_s;
      any_req_s = any_req_s | req_valid[ID_W'((int'(last_gnt_r) + k) % NUM_REQ)];
    end
  end

  assign can_accept_s = ~out_valid_r | out_ready;
  // Reset is folded in so no requester sees ready while the block is held in reset.
  assign xfer_s       = any_req_s & can_accept_s & ~flush & rst_n;
  assign comb_valid   = xfer_s;

  // Route the winner's operands to the shared unit and raise its ready.
  always_comb begin
    req_ready    = '0;
    comb_data_in = '0;
    comb_bias    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_s && (winner_s == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        comb_data_in = req_data[i*BITWIDTH +: BITWIDTH];
        comb_bias    = req_bias[i*BITWIDTH +: BITWIDTH];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Single-entry output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      last_gnt_r  <= ID_W'(NUM_REQ - 1);
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      last_gnt_r  <= ID_W'(NUM_REQ - 1);
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= comb_data_out;
      out_id_r    <= winner_s;
      last_gnt_r  <= winner_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;

`ifdef COMB_RR_SCHED_STAT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] xfer_cnt_r;

  // Stall cycles saturate; accepted transfers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
      xfer_cnt_r  <= 16'h0000;
    end else if (flush) begin
      stall_cnt_r <= 16'h0000;
      xfer_cnt_r  <= 16'h0000;
    end else begin
      if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end
      if (xfer_s) begin
        xfer_cnt_r <= xfer_cnt_r + 16'h0001;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign xfer_cnt  = xfer_cnt_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_comb_rr_sched.sv
// Scoreboard bench for comb_rr_sched; models the shared activation unit externally.
// Counter checks run only when COMB_RR_SCHED_STAT_EN is defined.
module tb_comb_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [31:0] req_bias;
  logic [7:0]  comb_data_in;
  logic [7:0]  comb_bias;
  logic        comb_valid;
  logic [7:0]  comb_data_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
`ifdef COMB_RR_SCHED_STAT_EN
  logic [15:0] stall_cnt;
  logic [15:0] xfer_cnt;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] bias_tab [4] = '{8'h05, 8'h08, 8'h0B, 8'h0E};

  always #5 clk = ~clk;

  // Stand-in activation unit: saturating 128 + 2*(d - b) on signed operands.
  function automatic logic [7:0] act(input logic [7:0] d, input logic [7:0] b);
    int x;
    int y;
    x = int'($signed(d)) - int'($signed(b));
    y = 128 + 2 * x;
    if (y < 0) y = 0;
    else if (y > 255) y = 255;
    return 8'(y);
  endfunction

  assign comb_data_out = act(comb_data_in, comb_bias);

  comb_rr_sched #(.BITWIDTH(8), .NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_bias(req_bias),
    .comb_data_in(comb_data_in), .comb_bias(comb_bias),
    .comb_valid(comb_valid), .comb_data_out(comb_data_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
`ifdef COMB_RR_SCHED_STAT_EN
    , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  // Pop the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got id=%0d data=%02h, required no output", out_id, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_id !== e.id || out_data !== e.data) begin
          bad++;
          $display("FAIL sb_output: got id=%0d data=%02h, required id=%0d data=%02h",
                   out_id, out_data, e.id, e.data);
        end
      end
    end
  end

  task automatic set_ops(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = base + 8'(i);
      req_bias[i*8 +: 8] = bias_tab[i];
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 4'b1111;
    set_ops(8'h10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
    total++; if (comb_valid !== 1'b0) begin bad++; $display("FAIL rst_comb_valid: got %b, required 0", comb_valid); end
    total++; if (out_data !== 8'h00 || out_id !== 2'd0) begin bad++; $display("FAIL rst_out_regs: got data=%02h id=%0d, required 00/0", out_data, out_id); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b, required 0001", req_ready); end
    sb_q.push_back('{id: 2'd0, data: act(8'h10, bias_tab[0])});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_rdy;
    do_flush();
    req_valid = 4'b1111; out_ready = 1'b1;
    set_ops(8'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (k % 4);
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rot_ready[%0d]: got %b, required %b", k, req_ready, exp_rdy); end
      total++; if (comb_valid !== 1'b1 || comb_data_in !== 8'h10 + 8'(k % 4) || comb_bias !== bias_tab[k % 4]) begin
        bad++; $display("FAIL rot_operands[%0d]: got v=%b d=%02h b=%02h, required 1/%02h/%02h",
                        k, comb_valid, comb_data_in, comb_bias, 8'h10 + 8'(k % 4), bias_tab[k % 4]);
      end
      if (k > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rot_out_valid[%0d]: got %b, required 1", k, out_valid); end
      end
      sb_q.push_back('{id: 2'(k % 4), data: act(8'h10 + 8'(k % 4), bias_tab[k % 4])});
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    total++; if (comb_valid !== 1'b0 || comb_data_in !== 8'h00 || comb_bias !== 8'h00) begin
      bad++; $display("FAIL idle_comb: got v=%b d=%02h b=%02h, required 0/00/00", comb_valid, comb_data_in, comb_bias);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sparse_rotation();
    logic [3:0] vpat [3] = '{4'b0100, 4'b1010, 4'b0010};
    logic [3:0] rpat [3] = '{4'b0100, 4'b1000, 4'b0010};
    logic [1:0] ids  [3] = '{2'd2, 2'd3, 2'd1};
    do_flush();
    out_ready = 1'b1;
    set_ops(8'h40);
    for (int k = 0; k < 3; k++) begin
      req_valid = vpat[k];
      @(negedge clk);
      total++; if (req_ready !== rpat[k]) begin bad++; $display("FAIL sparse_ready[%0d]: got %b, required %b", k, req_ready, rpat[k]); end
      sb_q.push_back('{id: ids[k], data: act(8'h40 + 8'(ids[k]), bias_tab[ids[k]])});
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [7:0] held;
    held = act(8'h71, bias_tab[1]);
    do_flush();
    out_ready = 1'b1; req_valid = 4'b0010;
    set_ops(8'h70);
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_first: got %b, required 0010", req_ready); end
    sb_q.push_back('{id: 2'd1, data: held});
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0000 || comb_valid !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b/%b, required 0000/0", k, req_ready, comb_valid); end
      total++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== held) begin
        bad++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d d=%02h, required 1/1/%02h", k, out_valid, out_id, out_data, held);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_refill: got %b, required 0010", req_ready); end
    sb_q.push_back('{id: 2'd1, data: held});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_keep_valid: got %b, required 1", out_valid); end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    do_flush();
    out_ready = 1'b1; req_valid = 4'b0001;
    set_ops(8'h20);
    @(negedge clk);
    sb_q.push_back('{id: 2'd0, data: act(8'h20, bias_tab[0])});
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 4'b0011;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000 || comb_valid !== 1'b0) begin bad++; $display("FAIL flush_no_xfer: got %b/%b, required 0000/0", req_ready, comb_valid); end
    sb_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL flush_restart: got %b, required 0001", req_ready); end
    sb_q.push_back('{id: 2'd0, data: act(8'h20, bias_tab[0])});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    do_flush();
    out_ready = 1'b1; req_valid = 4'b0100;
    set_ops(8'hC0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mrst_grant: got %b, required 0100", req_ready); end
    sb_q.push_back('{id: 2'd2, data: act(8'hC2, bias_tab[2])});
    @(posedge clk); #1;
    req_valid = 4'b0000; out_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
      bad++; $display("FAIL mrst_clear: got v=%b d=%02h id=%0d, required 0/00/0", out_valid, out_data, out_id);
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b0101; out_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mrst_restart: got %b, required 0001", req_ready); end
    sb_q.push_back('{id: 2'd0, data: act(8'hC0, bias_tab[0])});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

`ifdef COMB_RR_SCHED_STAT_EN
  task automatic test_stats();
    do_flush();
    req_valid = 4'b1111; out_ready = 1'b1;
    set_ops(8'h30);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sb_q.push_back('{id: 2'(k % 4), data: act(8'h30 + 8'(k % 4), bias_tab[k % 4])});
      @(posedge clk); #1;
    end
    req_valid = 4'b0000; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (xfer_cnt !== 16'd10) begin bad++; $display("FAIL stat_xfer: got %0d, required 10", xfer_cnt); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stat_stall: got %0d, required 3", stall_cnt); end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    do_flush();
    total++; if (xfer_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL stat_flush: got x=%0d s=%0d, required 0/0", xfer_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    req_data = '0; req_bias = '0;
    test_reset();
    test_rotation();
    test_sparse_rotation();
    test_stall();
    test_flush();
    test_reset_mid_stall();
`ifdef COMB_RR_SCHED_STAT_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
